mem_port_arbiter: RTL and testbench

Arbitrates a single-port, synchronous-read instruction/data memory between the instruction-fetch requester and the data (load/store) requester. It issues one memory command per cycle and sequences sub-word stores as read-modify-write. It returns a one-cycle `ack` pulse with read data to the granted requester. It sits between the IF/LSU bus interfaces and the SRAM macro, replacing direct dual-port access.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch and load/store requesters
// Alternating-priority grant, one command per cycle, sub-word stores as read-modify-write.
module mem_port_arbiter #(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_ack,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [3:0]        d_sel_byte,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              d_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, IF_RSP, D_RSP, MERGE} state_t;

    state_t              state;
    logic                prio_d;
    logic [MEM_AW-1:0]   addr_q;
    logic                we_q;
    logic                err_q;
    logic [XLEN-1:0]     wdata_q;
    logic [3:0]          sel_q;

    logic                grant_d;
    logic                grant_if;
    logic                d_full;
    logic                d_sub;
    logic [MEM_AW-1:0]   d_word;
    logic [MEM_AW-1:0]   if_word;
    logic [XLEN-1:0]     merged;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[XLEN-1:MEM_AW+2], if_addr[1:0],
                                d_addr[XLEN-1:MEM_AW+2], d_addr[1:0]};

    function automatic logic sub_word_sel(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: sub_word_sel = 1'b1;
            default:                                              sub_word_sel = 1'b0;
        endcase
    endfunction

    assign d_word   = d_addr[MEM_AW+1:2];
    assign if_word  = if_addr[MEM_AW+1:2];
    assign d_full   = (d_sel_byte == 4'b1111);
    assign d_sub    = sub_word_sel(d_sel_byte);
    assign grant_d  = d_req & (~if_req | prio_d);
    assign grant_if = if_req & ~grant_d;

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio_d  <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        addr_q  <= d_word;
                        we_q    <= d_we;
                        wdata_q <= d_wdata;
                        sel_q   <= d_sel_byte;
                        err_q   <= d_we & ~d_full & ~d_sub;
                        prio_d  <= 1'b0;
                        state   <= (d_we && d_sub) ? MERGE : D_RSP;
                    end else if (grant_if) begin
                        addr_q  <= if_word;
                        we_q    <= 1'b0;
                        err_q   <= 1'b0;
                        prio_d  <= 1'b1;
                        state   <= IF_RSP;
                    end
                end
                MERGE:   state <= D_RSP;
                IF_RSP:  state <= IDLE;
                D_RSP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // IDLE commands are gated by rst_n so nothing leaves the block while reset is held
    always_comb begin
        if_ack    = 1'b0;
        if_rdata  = '0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        d_busy    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (rst_n && grant_d) begin
                    if (!d_we || d_sub) begin
                        mem_en   = 1'b1;
                        mem_addr = d_word;
                    end else if (d_full) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = d_word;
                        mem_wdata = d_wdata;
                    end
                end else if (rst_n && grant_if) begin
                    mem_en   = 1'b1;
                    mem_addr = if_word;
                end
            end
            MERGE: begin
                d_busy    = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged;
            end
            IF_RSP: begin
                if_ack   = 1'b1;
                if_rdata = mem_rdata;
            end
            D_RSP: begin
                d_ack   = 1'b1;
                d_err   = err_q;
                d_rdata = we_q ? '0 : mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel_byte;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_busy;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .MEM_AW(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sel_byte(d_sel_byte), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .d_busy(d_busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h0000_0013;
        mem[8]  = 32'hAABB_CCDD;
        mem[12] = 32'h1234_5678;
        mem_rdata = 32'h0;

        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; d_wdata = 32'h0; d_sel_byte = 4'h0;
        tick(); tick();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_d_err", d_err, 0);
        check("rst_d_busy", d_busy, 0);

        rst_n = 1'b1; #1;
        check("first_grant_en", mem_en, 1);
        check("first_grant_is_d", mem_addr, 12);
        check("first_grant_rd", mem_we, 0);
        tick();
        check("load_ack", d_ack, 1);
        check("load_rdata", d_rdata, 32'h1234_5678);
        check("load_no_if_ack", if_ack, 0);
        check("rsp_no_cmd", mem_en, 0);
        d_req = 1'b0;
        tick();
        check("fetch_en", mem_en, 1);
        check("fetch_addr", mem_addr, 4);
        tick();
        check("fetch_ack", if_ack, 1);
        check("fetch_rdata", if_rdata, 32'h0000_0013);
        check("fetch_no_d_ack", d_ack, 0);
        if_req = 1'b0;
        tick();
        check("idle_no_cmd", mem_en, 0);
        check("idle_if_rdata", if_rdata, 0);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h21; d_sel_byte = 4'b0010; d_wdata = 32'h0000_5500;
        #1;
        check("sub_rd_en", mem_en, 1);
        check("sub_rd_we", mem_we, 0);
        check("sub_rd_addr", mem_addr, 8);
        check("sub_busy0", d_busy, 0);
        tick();
        d_req = 1'b0; d_wdata = 32'hFFFF_FFFF; d_sel_byte = 4'hF;
        #1;
        check("sub_busy1", d_busy, 1);
        check("sub_wr_en", mem_en, 1);
        check("sub_wr_we", mem_we, 1);
        check("sub_wr_addr", mem_addr, 8);
        check("sub_wr_data", mem_wdata, 32'hAABB_55DD);
        check("sub_no_ack_yet", d_ack, 0);
        tick();
        check("sub_ack", d_ack, 1);
        check("sub_rdata", d_rdata, 0);
        check("sub_err", d_err, 0);
        check("sub_busy2", d_busy, 0);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        tick();
        check("reload_ack", d_ack, 1);
        check("reload_rdata", d_rdata, 32'hAABB_55DD);
        d_req = 1'b0;
        tick();

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_sel_byte = 4'hF; d_wdata = 32'hDEAD_BEEF;
        #1;
        check("full_wr_we", mem_we, 1);
        check("full_wr_addr", mem_addr, 16);
        check("full_wr_data", mem_wdata, 32'hDEAD_BEEF);
        tick();
        d_req = 1'b0; #1;
        check("full_ack", d_ack, 1);
        check("full_busy", d_busy, 0);
        tick();
        check("full_mem", mem[16], 32'hDEAD_BEEF);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_sel_byte = 4'b0101; d_wdata = 32'h1111_1111;
        #1;
        check("ill_no_cmd", mem_en, 0);
        tick();
        d_req = 1'b0; #1;
        check("ill_ack", d_ack, 1);
        check("ill_err", d_err, 1);
        check("ill_rsp_no_cmd", mem_en, 0);
        tick();
        check("ill_err_clear", d_err, 0);
        check("ill_mem_kept", mem[8], 32'hAABB_55DD);

        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'hFFC0_0013;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        tick();
        rst_n = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            check("arb_en", mem_en, 1);
            check("arb_addr", mem_addr, (k % 2 == 0) ? 32'd12 : 32'd4);
            tick();
            check("arb_d_ack", d_ack, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("arb_if_ack", if_ack, (k % 2 == 0) ? 32'd0 : 32'd1);
            check("arb_rdata", (k % 2 == 0) ? d_rdata : if_rdata,
                  (k % 2 == 0) ? 32'h1234_5678 : 32'h0000_0013);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_sel_byte = 4'b0001; d_wdata = 32'h0000_00EE;
        #1;
        check("rstmid_rd_addr", mem_addr, 4);
        tick();
        check("rstmid_merge", d_busy, 1);
        rst_n = 1'b0; #1;
        check("rstmid_no_wr", mem_en, 0);
        check("rstmid_busy", d_busy, 0);
        d_req = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        check("rstmid_no_ack", d_ack, 0);
        check("rstmid_idle", mem_en, 0);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        tick();
        check("rstmid_ack", d_ack, 1);
        check("rstmid_word_kept", d_rdata, 32'h0000_0013);
        d_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
